// File: rtl/div_issue_ctrl.sv
// EX-stage controller for the multi-cycle divider: latches operands, holds
// start until ready, stalls the pipe, writes HI/LO, and recovers from flush
// or an unresponsive divider by annulling and draining back to idle.
module div_issue_ctrl #(
  parameter int MAX_WAIT     = 48,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_req_i,
  input  logic        signed_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        start_o,
  output logic        annul_o,
  output logic        signed_div_o,
  output logic [31:0] opdata1_o,
  output logic [31:0] opdata2_o,
  input  logic [63:0] result_i,
  input  logic        ready_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        hilo_we_o,
  output logic        timeout_o
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE, S_DRAIN} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          sgn_q, sgn_d;
  logic [31:0]   op1_q, op1_d, op2_q, op2_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic          we_q, we_d;
  logic          timeout;

  // Next-state, operand capture, result capture and stall generation
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    drain_d = drain_q;
    sgn_d   = sgn_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    we_d    = 1'b0;
    timeout = 1'b0;
    stall_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (div_req_i && !flush_i) begin
          stall_o = 1'b1;
          sgn_d   = signed_i;
          op1_d   = rs_i;
          op2_d   = rt_i;
          wait_d  = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        // dropping stall with ready lets the instruction advance as HI/LO land
        stall_o = !ready_i && !flush_i;
        wait_d  = wait_q + CW'(1);
        if (flush_i) begin
          drain_d = '0;
          state_d = S_DRAIN;
        end else if (ready_i) begin
          hi_d    = result_i[63:32];
          lo_d    = result_i[31:0];
          we_d    = 1'b1;
          state_d = S_DONE;
        end else if (wait_q == CW'(MAX_WAIT - 1)) begin
          timeout = 1'b1;
          drain_d = '0;
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        // one idle beat so the divider sees start low and leaves its end state
        stall_o = div_req_i;
        state_d = S_IDLE;
      end
      S_DRAIN: begin
        stall_o = div_req_i && !flush_i;
        drain_d = drain_q + DW'(1);
        if (drain_q == DW'(DRAIN_CYCLES - 1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset also abandons any in-flight divide
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      drain_q <= '0;
      sgn_q   <= 1'b0;
      op1_q   <= '0;
      op2_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      drain_q <= drain_d;
      sgn_q   <= sgn_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      we_q    <= we_d;
    end
  end

  assign start_o      = (state_q == S_BUSY);
  assign annul_o      = (state_q == S_DRAIN);
  assign signed_div_o = sgn_q;
  assign opdata1_o    = op1_q;
  assign opdata2_o    = op2_q;
  assign hi_o         = hi_q;
  assign lo_o         = lo_q;
  assign hilo_we_o    = we_q;
  assign timeout_o    = timeout;
endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: a behavioural divider answers the handshake, the
// stimulus pushes expected HI/LO writes or timeouts, a monitor pops them.
module tb_div_issue_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        div_req_i, signed_i, flush_i;
  logic [31:0] rs_i, rt_i;
  logic        stall_o, start_o, annul_o, signed_div_o;
  logic [31:0] opdata1_o, opdata2_o, hi_o, lo_o;
  logic [63:0] result_i;
  logic        ready_i;
  logic        hilo_we_o, timeout_o;

  div_issue_ctrl #(.MAX_WAIT(48), .DRAIN_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .div_req_i(div_req_i), .signed_i(signed_i),
    .rs_i(rs_i), .rt_i(rt_i), .flush_i(flush_i), .stall_o(stall_o),
    .start_o(start_o), .annul_o(annul_o), .signed_div_o(signed_div_o),
    .opdata1_o(opdata1_o), .opdata2_o(opdata2_o), .result_i(result_i),
    .ready_i(ready_i), .hi_o(hi_o), .lo_o(lo_o), .hilo_we_o(hilo_we_o),
    .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct {bit to; logic [31:0] hi; logic [31:0] lo;} exp_t;
  exp_t sb[$];
  exp_t me;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, an_cnt = 0, we_cnt = 0;
  int last_st, to_at, start_cyc, ready_cyc;
  bit div_hang = 0;
  int dv_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  always @(posedge clk) cyc++;

  // Divider model: ready in the 36th start cycle (4th for divide-by-zero)
  always @(posedge clk or posedge rst) begin
    #1;
    if (rst || !start_o) begin
      dv_cnt   = 0;
      ready_i  = 1'b0;
      result_i = 64'd0;
    end else begin
      dv_cnt++;
      if (!div_hang && dv_cnt == ((opdata2_o == 32'd0) ? 4 : 36)) begin
        ready_i  = 1'b1;
        result_i = ref_div(signed_div_o, opdata1_o, opdata2_o);
      end else begin
        ready_i  = 1'b0;
        result_i = 64'd0;
      end
    end
  end

  // Monitor: every write strobe or timeout consumes one scoreboard entry
  always @(negedge clk) begin
    #3;
    if (!rst) begin
      if (annul_o) an_cnt++;
      if (hilo_we_o) we_cnt++;
      if (hilo_we_o || timeout_o) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_event: got we=%0b to=%0b want none", hilo_we_o, timeout_o);
        end else begin
          me = sb.pop_front();
          check("event_is_timeout", {63'd0, timeout_o}, {63'd0, me.to});
          check("event_we", {63'd0, hilo_we_o}, {63'd0, !me.to});
          if (!me.to) begin
            check("hi_o", {32'd0, hi_o}, {32'd0, me.hi});
            check("lo_o", {32'd0, lo_o}, {32'd0, me.lo});
          end
        end
      end
    end
  end

  // Present one divide in EX (called at a negedge); returns at the negedge
  // after the instruction left EX or was killed, leaving div_req_i high.
  task automatic issue(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                       input int flush_at, input bit hang);
    exp_t e;
    logic [63:0] r;
    int st = 0, guard = 0;
    bit done = 0, saw_an = 0;
    div_hang  = hang;
    div_req_i = 1'b1;
    signed_i  = sgn;
    rs_i      = a;
    rt_i      = b;
    if (hang) begin
      e.to = 1'b1; e.hi = '0; e.lo = '0;
      sb.push_back(e);
    end else if (flush_at < 0) begin
      r = ref_div(sgn, a, b);
      e.to = 1'b0; e.hi = r[63:32]; e.lo = r[31:0];
      sb.push_back(e);
    end
    to_at = -1;
    while (!done && guard < 200) begin
      #1;
      if (start_o) begin
        st++;
        if (st == 1) start_cyc = cyc;
      end
      if (timeout_o) to_at = st;
      if (annul_o) saw_an = 1;
      if (start_o && flush_at > 0 && st == flush_at) flush_i = 1'b1;
      // the timeout is taken as an exception once the divider is drained
      if (hang && saw_an && !annul_o) flush_i = 1'b1;
      #1;
      if (start_o && ready_i && !flush_i) begin
        ready_cyc = cyc;
        check("stall_low_on_ready", {63'd0, stall_o}, 64'd0);
      end
      if (!stall_o) done = 1;
      else begin
        @(negedge clk);
        flush_i = 1'b0;
        guard++;
      end
    end
    check("issue_completed", {63'd0, done}, 64'd1);
    @(negedge clk);
    flush_i = 1'b0;
    last_st = st;
  endtask

  task automatic idle(input int n);
    div_req_i = 1'b0;
    flush_i   = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  int a0, w0, r1;
  logic [31:0] ra, rb;
  bit rs;
  int fa;

  initial begin
    rst = 1'b1; div_req_i = 0; signed_i = 0; flush_i = 0; rs_i = 0; rt_i = 0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_start", {63'd0, start_o}, 0);
    check("rst_annul", {63'd0, annul_o}, 0);
    check("rst_stall", {63'd0, stall_o}, 0);
    check("rst_we", {63'd0, hilo_we_o}, 0);
    check("rst_hilo", {hi_o, lo_o}, 0);
    check("rst_ops", {opdata1_o, opdata2_o}, 0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // DIVU 100/7
    issue(0, 32'd100, 32'd7, -1, 0);
    check("divu_start_cycles", last_st, 36);
    idle(3);
    check("hold_hi_lo", {hi_o, lo_o}, {32'd2, 32'd14});

    // DIV -7/2
    issue(1, 32'hFFFF_FFF9, 32'd2, -1, 0);
    idle(3);
    check("div_neg_hi_lo", {hi_o, lo_o}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

    // divide by zero
    w0 = we_cnt;
    issue(1, 32'd1234, 32'd0, -1, 0);
    check("divzero_start_cycles", last_st, 4);
    idle(3);
    check("divzero_we_once", we_cnt - w0, 1);

    // flush at BUSY cycle 10, then DIVU 9/4
    a0 = an_cnt; w0 = we_cnt;
    issue(0, 32'd500, 32'd3, 10, 0);
    idle(4);
    check("flush_annul_cycles", an_cnt - a0, 2);
    check("flush_no_write", we_cnt - w0, 0);
    check("flush_hilo_held", {hi_o, lo_o}, 64'd0);
    issue(0, 32'd9, 32'd4, -1, 0);
    idle(2);

    // back-to-back: second request already waiting in the DONE cycle;
    // start rises two edges after the edge that samples ready
    issue(0, 32'd20, 32'd3, -1, 0);
    r1 = ready_cyc;
    issue(0, 32'd50, 32'd5, -1, 0);
    check("b2b_start_gap", start_cyc - r1, 3);
    idle(3);

    // divider never answers
    a0 = an_cnt; w0 = we_cnt;
    issue(0, 32'd77, 32'd5, -1, 1);
    check("timeout_busy_cycle", to_at, 48);
    idle(3);
    check("timeout_annul_cycles", an_cnt - a0, 2);
    check("timeout_no_write", we_cnt - w0, 0);

    // randomized divides with occasional flush (up to the ready cycle)
    for (int i = 0; i < 12; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = $urandom_range(1, 20);
        2: rb = -$urandom_range(1, 20);
        default: rb = $urandom;
      endcase
      if (rs && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd1;
      fa = ($urandom_range(0, 3) == 0) ? $urandom_range(1, (rb == 0) ? 4 : 36) : -1;
      issue(rs, ra, rb, fa, 0);
      idle($urandom_range(1, 3) + ((fa > 0) ? 2 : 0));
    end

    // reset while busy
    div_req_i = 1; signed_i = 0; rs_i = 32'd100; rt_i = 32'd7;
    repeat (6) @(negedge clk);
    div_req_i = 0;
    rst = 1'b1;
    #1;
    check("midrst_start", {63'd0, start_o}, 0);
    check("midrst_stall", {63'd0, stall_o}, 0);
    check("midrst_hilo", {hi_o, lo_o}, 0);
    check("midrst_ops", {opdata1_o, opdata2_o}, 0);
    @(negedge clk);
    rst = 1'b0;
    idle(4);
    check("midrst_still_idle", {62'd0, start_o, annul_o}, 0);

    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
